// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO controllers: pointer widths,
// producer identifiers and the Gray-code helpers used by both clock domains.
package fifo_pkg;

    // Default geometry of the FIFO. The controllers take these as parameter defaults.
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int PTR_WIDTH      = ADDR_WIDTH_DEF + 1;

    // Helpers work on a wide container so any pointer width up to 32 bits fits.
    localparam int PTR_MAX = 32;
    typedef logic [PTR_MAX-1:0] ptr_max_t;

    // Identity of a write producer.
    typedef enum logic [0:0] {
        PROD0 = 1'b0,
        PROD1 = 1'b1
    } prod_id_e;

    // Binary to reflected Gray code. Zero-extended inputs give zero-extended results.
    function automatic ptr_max_t bin2gray(input ptr_max_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Compare two Gray pointers of width pw. With invert_msbs set, the two top
    // bits of b are flipped first: that is the "one full lap apart" test used
    // for the full flag. With invert_msbs clear it is a plain equality, which
    // is the empty test on the read side.
    function automatic logic gray_ptr_match(input ptr_max_t a,
                                            input ptr_max_t b,
                                            input int       pw,
                                            input logic     invert_msbs);
        ptr_max_t mask;
        if (invert_msbs) begin
            mask = ptr_max_t'(2'b11) << (pw - 2);
        end else begin
            mask = '0;
        end
        return (a == (b ^ mask));
    endfunction

endpackage

// File: rtl/wr_gray_ptr.sv
// Binary/Gray pointer pair for one side of the asynchronous FIFO. The pointer
// advances by one when i_inc is set; o_bin_next/o_gray_next expose the value
// it will hold after the coming edge so flag logic can be registered in step.
module wr_gray_ptr
    import fifo_pkg::*;
#(
    parameter int PTR_W = fifo_pkg::PTR_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_bin,
    output logic [PTR_W-1:0] o_bin_next,
    output logic [PTR_W-1:0] o_gray,
    output logic [PTR_W-1:0] o_gray_next
);

    logic [PTR_W-1:0] r_bin;
    logic [PTR_W-1:0] r_gray;
    logic [PTR_W-1:0] w_bin_next;
    logic [PTR_W-1:0] w_gray_next;

    // Next pointer value: natural wrap modulo 2**PTR_W, Gray form derived from it.
    always_comb begin
        w_bin_next  = r_bin + {{(PTR_W-1){1'b0}}, i_inc};
        w_gray_next = PTR_W'(bin2gray(ptr_max_t'(w_bin_next)));
    end

    // Pointer registers; synchronous clear returns both forms to zero.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_bin  <= {PTR_W{1'b0}};
            r_gray <= {PTR_W{1'b0}};
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
        end
    end

    assign o_bin       = r_bin;
    assign o_bin_next  = w_bin_next;
    assign o_gray      = r_gray;
    assign o_gray_next = w_gray_next;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side controller of the asynchronous FIFO. Round-robin arbitrates two
// producers onto the RAM write port, owns the write pointer and produces a
// registered full flag against the already-synchronised read pointer.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  clr_in,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  grant_id
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    logic                  r_full;
    prod_id_e              r_last_grant;

    logic                  w_gnt_valid;
    prod_id_e              w_gnt_id;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [PTR_W-1:0]      w_wbin;
    logic [PTR_W-1:0]      w_wbin_next;
    logic [PTR_W-1:0]      w_wgray;
    logic [PTR_W-1:0]      w_wgray_next;
    logic                  w_full_next;

    // Round-robin grant: nothing while clearing or full; on a tie the
    // producer that did not win last time gets the port.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = PROD0;
        if (clr_in || r_full) begin
            w_gnt_valid = 1'b0;
            w_gnt_id    = PROD0;
        end else if (req0_valid && req1_valid) begin
            w_gnt_valid = 1'b1;
            w_gnt_id    = prod_id_e'(~r_last_grant);
        end else if (req0_valid) begin
            w_gnt_valid = 1'b1;
            w_gnt_id    = PROD0;
        end else if (req1_valid) begin
            w_gnt_valid = 1'b1;
            w_gnt_id    = PROD1;
        end else begin
            w_gnt_valid = 1'b0;
            w_gnt_id    = PROD0;
        end
    end

    // Write data mux follows the grant; idle cycles drive zeros onto the bus.
    always_comb begin
        w_wdata = {DATA_WIDTH{1'b0}};
        if (w_gnt_valid) begin
            case (w_gnt_id)
                PROD0:   w_wdata = req0_data;
                PROD1:   w_wdata = req1_data;
                default: w_wdata = {DATA_WIDTH{1'b0}};
            endcase
        end else begin
            w_wdata = {DATA_WIDTH{1'b0}};
        end
    end

    // Write pointer; it advances on every accepted word.
    wr_gray_ptr #(
        .PTR_W (PTR_W)
    ) u_wptr (
        .i_clk       (clk),
        .i_clr       (clr_in),
        .i_inc       (w_gnt_valid),
        .o_bin       (w_wbin),
        .o_bin_next  (w_wbin_next),
        .o_gray      (w_wgray),
        .o_gray_next (w_wgray_next)
    );

    // Full when the post-write pointer is exactly one lap ahead of the read
    // pointer. Using the current read pointer with the new write pointer can
    // only report full early, never late, so no word is ever overwritten.
    always_comb begin
        w_full_next = gray_ptr_match(ptr_max_t'(w_wgray_next),
                                     ptr_max_t'(rptr_gray_sync),
                                     PTR_W, 1'b1);
    end

    // Full flag and round-robin history registers.
    always_ff @(posedge clk) begin
        if (clr_in) begin
            r_full       <= 1'b0;
            r_last_grant <= PROD1;
        end else begin
            r_full <= w_full_next;
            if (w_gnt_valid) begin
                r_last_grant <= w_gnt_id;
            end else begin
                r_last_grant <= r_last_grant;
            end
        end
    end

    assign req0_ready = w_gnt_valid && (w_gnt_id == PROD0);
    assign req1_ready = w_gnt_valid && (w_gnt_id == PROD1);
    assign wen        = w_gnt_valid;
    // The pointer MSB only distinguishes laps; it never addresses the RAM.
    assign waddr      = w_wbin[ADDR_WIDTH-1:0];
    assign wdata      = w_wdata;
    assign grant_id   = w_gnt_id;
    assign wptr_gray  = w_wgray;
    assign full       = r_full;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Write-side controller for the team's asynchronous FIFO. Arbitrates two producers onto the single FIFO write port using round-robin arbitration, and owns the write pointer in binary and Gray form. Computes the registered full flag against the read pointer, which arrives already synchronised into this clock domain. Drives the RAM write strobe/address/data and exports the Gray write pointer for synchronisation into the read domain.

Parameters:
ADDR_WIDTH, 4, RAM address bits; FIFO depth = 2**ADDR_WIDTH (16)
DATA_WIDTH, 8, width of each write word

Ports:
clk  in  1  write-domain clock
clr_in  in  1  reset: synchronous, active-high; all state cleared on the clk edge where clr_in=1
req0_valid  in  1  producer 0 has a word
req0_data  in  DATA_WIDTH  producer 0 word
req0_ready  out  1  producer 0 word accepted this cycle
req1_valid  in  1  producer 1 has a word
req1_data  in  DATA_WIDTH  producer 1 word
req1_ready  out  1  producer 1 word accepted this cycle
rptr_gray_sync  in  ADDR_WIDTH+1  read pointer (Gray), already double-synchronised
wptr_gray  out  ADDR_WIDTH+1  registered write pointer (Gray), to read-domain synchroniser
wen  out  1  RAM write enable
waddr  out  ADDR_WIDTH  RAM write address = wbin[ADDR_WIDTH-1:0]
wdata  out  DATA_WIDTH  RAM write data (mux of granted producer)
full  out  1  registered full flag
grant_id  out  1  index of the producer granted this cycle (valid only when wen=1)

Behaviour:
- State:
  - wbin: binary pointer, ADDR_WIDTH+1 bits.
  - wptr_gray: Gray pointer = wbin ^ (wbin>>1), held registered.
  - full: registered flag.
  - last_grant: 1 bit.
- Reset (clr_in=1 at edge): wbin=0, wptr_gray=0, full=0, last_grant=1 (so producer 0 wins the first tie).
  - While clr_in=1: req*_ready=0 and wen=0 combinationally, so no write is accepted in a reset cycle.
  - A reset mid-stream discards pointer state; the in-flight word is not written.
- Arbitration (combinational, per cycle, when clr_in=0 and full=0):
  - Only one valid: grant it.
  - Both valid: grant ~last_grant.
  - None valid: no grant.
  - When full=1: no grant, all ready=0.
- Handshake:
  - reqN_ready = granted N. A transfer occurs when valid and ready are both 1.
  - ready may depend on valid; producers must hold valid and data stable until ready.
  - A producer must not drop valid without a transfer.
- Write: on transfer, wen=1, waddr=wbin[ADDR_WIDTH-1:0], wdata=granted data, grant_id=N, all in the same cycle. RAM captures on the same edge.
- Pointer update at edge:
  - wbin_next = wbin + wen (modulo 2**(ADDR_WIDTH+1), natural wrap).
  - wptr_gray <= Gray(wbin_next).
  - last_grant <= grant_id if wen, else unchanged.
- Full:
  - full <= (Gray(wbin_next) == {~rptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1], rptr_gray_sync[ADDR_WIDTH-2:0]}).
  - Evaluated every cycle, so full deasserts one edge after rptr_gray_sync advances.
  - Full asserts on the edge that completes the 2**ADDR_WIDTH-th outstanding write, so there is no overflow.
- Latency:
  - An accepted word appears in wptr_gray 1 cycle after the transfer.
  - Read-pointer movement is reflected in full 1 cycle after rptr_gray_sync changes.
- Simultaneous write on the same edge as rptr_gray_sync changes: full uses the new wbin_next and the current rptr_gray_sync. This is pessimistic and safe.
- Wrap-around: after 2**(ADDR_WIDTH+1) writes, wbin=0 and wptr_gray=0. waddr wraps every 2**ADDR_WIDTH writes.
- The MSB of wbin is never used as an address bit.

Decomposition:
- Shared package fifo_pkg:
  - PTR_WIDTH = ADDR_WIDTH+1.
  - bin2gray function.
  - full-compare helper, which also serves the read side's empty logic.
- One sub-module, wr_gray_ptr: holds wbin/wptr_gray with clr_in/inc inputs and outputs wbin_next and the Gray pointer. It is reused by the future read-side controller.
- The arbiter and full logic stay in the top module.

Test Plan:
- Reset: clr_in=1 for 2 cycles with req0_valid=req1_valid=1 -> req0_ready=req1_ready=0, wen=0; after the edge wptr_gray=0, full=0.
- Single producer, rptr_gray_sync=0: req0_valid=1 held for 17 cycles -> 16 transfers at waddr 0..15; wptr_gray follows 0,1,3,2,6,...; after the 16th, wptr_gray=5'b11000 and full=1; the 17th cycle has req0_ready=0 and wen=0.
- Both producers valid, FIFO never full (rptr tracks writes) -> grant_id sequence 0,1,0,1,...; after producer 1 drops valid, producer 0 is granted every cycle.
- Full release: FIFO full at wptr_gray=5'b11000; set rptr_gray_sync=5'b00001 -> full=0 one edge later; the next req1 word is written to waddr 0 and full=1 again.
- Wrap: 32 writes with rptr_gray_sync tracking -> waddr wraps 15->0 twice; wptr_gray returns to 0; full is never asserted.
- Mid-stream reset: after 5 writes (wptr_gray=5'b00111), pulse clr_in=1 for one cycle with req0_valid=1 -> no write that cycle; wptr_gray=0, full=0; the next transfer goes to waddr 0 with grant to producer 0.
